onchip_mem_arbiter: RTL
=======================

// Module: onchip_mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter sharing the single-port 1024x32 on-chip RAM.
//  Master 0 is the CPU data port; master 1 is the RNG result writer/reader.
//  Grants at most one Avalon-MM command per cycle to the RAM.
//  Tags reads in flight and routes readdata/readdatavalid back to the owner.
// PARAMETERS
//  ADDR_W        10  word address width (RAM depth 2**ADDR_W)
//  DATA_W        32  data width; byteenable width = DATA_W/8
//  READ_LATENCY  1   RAM clocks from accepted read to valid q (legal 1..2)
//  FIXED_PRIO    0   0 = round-robin; 1 = master 0 always wins
// PORTS
//  clk              in   1         system clock
//  reset_n          in   1         async active-low reset
//  mN_address       in   ADDR_W    master N (N=0,1) word address
//  mN_byteenable    in   DATA_W/8  master N byte lanes
//  mN_read          in   1         master N read request
//  mN_write         in   1         master N write request
//  mN_writedata     in   DATA_W    master N write data
//  mN_waitrequest   out  1         high = command not accepted this cycle
//  mN_readdata      out  DATA_W    read data to master N
//  mN_readdatavalid out  1         one-cycle strobe, mN_readdata valid
//  mem_address      out  ADDR_W    RAM address
//  mem_byteenable   out  DATA_W/8  RAM byte lanes
//  mem_chipselect   out  1         RAM select (high only on granted cycle)
//  mem_write        out  1         RAM write enable
//  mem_writedata    out  DATA_W    RAM write data
//  mem_clken        out  1         RAM clock enable; tied 1 out of reset
//  mem_readdata     in   DATA_W    RAM q (unregistered)
// BEHAVIOUR
//  - Reset (async, reset_n low): last_grant<=1 (m0 wins first contest), latency
//    tag pipeline cleared, both readdatavalid 0, mem_chipselect 0, both
//    waitrequest 1, mem_clken 0. In-flight reads at reset are discarded.
//  - Request: reqN = mN_read | mN_write. read&write together = write only.
//  - Grant (combinational, same cycle): one requester -> it wins; both ->
//    master != last_grant wins (FIXED_PRIO=1: m0 wins). grantN drives mem_*
//    mux; mN_waitrequest = reqN & ~grantN (0 when idle).
//  - last_grant updates on the rising edge only when a grant is issued.
//  - Zero-wait issue: an accepted command reaches the RAM in the same cycle;
//    back-to-back accepts from one master allowed every cycle if uncontested.
//  - Read return: tag {valid, owner} shifted through READ_LATENCY stages;
//    at stage end, owner's readdatavalid=1 and readdata=mem_readdata;
//    other master's readdatavalid=0. readdata to both is mem_readdata (don't
//    care when not valid). Returns in issue order; no reordering.
//  - Writes produce no response. Read then write to the same address on
//    consecutive cycles: read returns old data.
//  - Pipeline full never stalls: up to READ_LATENCY reads outstanding, one
//    return per cycle max, so no backpressure path exists.
//  - Address wrap: no arithmetic on addresses; passed through unchanged.
//  - Starvation bound: under continuous contention each master waits <=1 cycle.
// TESTING
//  1 Reset: reset_n=0 mid read -> no readdatavalid after release; m0_waitrequest
//    =1 while in reset; first contest after reset grants m0.
//  2 m0 write addr 0x005 data 0xDEADBEEF be=4'hF, then m1 read 0x005 ->
//    m1_readdatavalid one cycle after accept, m1_readdata=0xDEADBEEF.
//  3 Both read every cycle for 8 cycles (m0 @0x010.., m1 @0x020..) -> grants
//    alternate m0,m1,..; each gets 4 returns in order; no lost valids.
//  4 Byte lanes: write 0x11223344 be=4'b0101 over 0xFFFFFFFF @0x3FF -> read
//    returns 0xFF22FF44; address 0x3FF top of RAM reached without wrap.
//  5 m0 read+write asserted together @0x001 -> treated as write, no
//    readdatavalid; FIXED_PRIO=1 contention run -> m1 waits while m0 requests.
//  6 READ_LATENCY=2 build: 2 outstanding reads back-to-back -> valids on
//    cycles +2 and +3, owners correct.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of the single-port on-chip RAM: zero-wait command
// issue, round-robin or fixed priority, and owner-tagged read return routing.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic                    running;
  logic                    last_grant;
  logic                    req0, req1;
  logic                    grant0, grant1;
  logic                    issue_read;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Nothing is granted until the first clock after reset release.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (running) begin
      if (req0 && req1) begin
        if (FIXED_PRIO != 0 || last_grant) grant0 = 1'b1;
        else                               grant1 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign m0_waitrequest = ~running | (req0 & ~grant0);
  assign m1_waitrequest = ~running | (req1 & ~grant1);

  assign mem_address    = grant1 ? m1_address    : m0_address;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = grant0 | grant1;
  assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_clken      = running;
  assign issue_read     = mem_chipselect & ~mem_write;

  // Tag pipeline mirrors the RAM read latency; the last stage marks returning data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running    <= 1'b0;
      last_grant <= 1'b1;
      tag_valid  <= '0;
      tag_owner  <= '0;
    end else begin
      running <= 1'b1;
      if (grant0 || grant1) last_grant <= grant1;
      tag_valid <= READ_LATENCY'({tag_valid, issue_read});
      tag_owner <= READ_LATENCY'({tag_owner, grant1});
    end
  end

  assign m0_readdatavalid = tag_valid[READ_LATENCY-1] & ~tag_owner[READ_LATENCY-1];
  assign m1_readdatavalid = tag_valid[READ_LATENCY-1] &  tag_owner[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
